// File: rtl/atan2_18_pkg.sv
// Shared constants and helpers for the atan2_18 CORDIC vectoring pipeline.
package atan2_18_pkg;

  localparam int NBD_DEF = 18;
  localparam int NBA_DEF = 22;
  localparam int NIT_DEF = 20;
  localparam int NG_DEF  = 3;

  // Pipeline depth: fold stage + one stage per iteration + output stage.
  function automatic int lat_of(input int nit);
    return nit + 2;
  endfunction

  // Internal x/y width: two headroom bits for CORDIC gain plus guard LSBs.
  function automatic int xw_of(input int nbd, input int ng);
    return nbd + 2 + ng;
  endfunction

  localparam int LAT = lat_of(NIT_DEF);
  localparam int XW  = xw_of(NBD_DEF, NG_DEF);

  // ATAN[k] = round(atan(2^-k) * 2^nba / (2*pi)), evaluated at elaboration.
  // k = 0 is exactly 1/8 turn; for k >= 1 the Taylor series converges fast.
  function automatic int atan_cnt(input int k, input int nba);
    real t, p, s, sc;
    if (k == 0) return 1 << (nba - 3);
    t = 1.0;
    for (int j = 0; j < k; j++) t = t / 2.0;
    s = 0.0;
    p = t;
    for (int n = 0; n < 30; n++) begin
      if (n % 2 == 0) s = s + p / real'(2 * n + 1);
      else            s = s - p / real'(2 * n + 1);
      p = p * t * t;
    end
    sc = 1.0;
    for (int j = 0; j < nba; j++) sc = sc * 2.0;
    return $rtoi(s * sc / 6.283185307179586 + 0.5);
  endfunction

endpackage

// File: rtl/atan2_18_cordic_vec_stage.sv
// One registered CORDIC vectoring iteration: rotates toward y = 0.
module cordic_vec_stage
  import atan2_18_pkg::*;
#(
  parameter int XW_P = XW,
  parameter int NBA  = NBA_DEF,
  parameter int K    = 0
) (
  input  logic                   c,
  input  logic                   rst_n,
  input  logic signed [XW_P-1:0] x_i,
  input  logic signed [XW_P-1:0] y_i,
  input  logic        [NBA-1:0]  z_i,
  output logic signed [XW_P-1:0] x_o,
  output logic signed [XW_P-1:0] y_o,
  output logic        [NBA-1:0]  z_o
);

  localparam logic [NBA-1:0] ATAN_K = NBA'(atan_cnt(K, NBA));

  logic signed [XW_P-1:0] x_d, y_d, x_q, y_q;
  logic        [NBA-1:0]  z_d, z_q;

  // Both updates use the incoming x/y; z wraps modulo 2^NBA.
  always_comb begin
    if (!y_i[XW_P-1]) begin
      x_d = x_i + (y_i >>> K);
      y_d = y_i - (x_i >>> K);
      z_d = z_i + ATAN_K;
    end else begin
      x_d = x_i - (y_i >>> K);
      y_d = y_i + (x_i >>> K);
      z_d = z_i - ATAN_K;
    end
  end

  // Stage register, cleared by reset so flushed samples leave no residue.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign z_o = z_q;

endmodule

// File: rtl/atan2_18.sv
// Fully pipelined atan2/magnitude via CORDIC vectoring, latency NIT+2.
module atan2_18
  import atan2_18_pkg::*;
#(
  parameter int NBD = NBD_DEF,
  parameter int NBA = NBA_DEF,
  parameter int NIT = NIT_DEF,
  parameter int NG  = NG_DEF
) (
  input  logic                  c,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic signed [NBD-1:0] i,
  input  logic signed [NBD-1:0] q,
  output logic                  o_valid,
  output logic        [NBA-1:0] o_phase,
  output logic        [NBD:0]   o_mag
);

  localparam int PIPE_LAT = lat_of(NIT);
  localparam int XDW      = xw_of(NBD, NG);
  localparam logic [NBA-1:0] HALF_TURN = {1'b1, {(NBA-1){1'b0}}};

  logic [PIPE_LAT-1:0] vld_pipe_d, vld_pipe_q;
  logic [NIT:0]        zero_pipe_d, zero_pipe_q;

  logic signed [XDW-1:0] i_ext, q_ext;
  logic signed [XDW-1:0] fold_x_d, fold_y_d, fold_x_q, fold_y_q;
  logic        [NBA-1:0] fold_z_d, fold_z_q;

  logic signed [XDW-1:0] xs [NIT+1];
  logic signed [XDW-1:0] ys [NIT+1];
  logic        [NBA-1:0] zs [NIT+1];

  logic [NBA-1:0] phase_d, phase_q;
  logic [NBD:0]   mag_d, mag_q;

  // Valid and zero-input flags ride alongside the data as shift chains.
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[PIPE_LAT-2:0], i_valid};
    zero_pipe_d = {zero_pipe_q[NIT-1:0], (i == '0) && (q == '0)};
  end

  // Fold into the right half-plane; the extra top bit keeps -(-2^(NBD-1)) exact.
  always_comb begin
    i_ext = {{2{i[NBD-1]}}, i, {NG{1'b0}}};
    q_ext = {{2{q[NBD-1]}}, q, {NG{1'b0}}};
    if (i[NBD-1]) begin
      fold_x_d = -i_ext;
      fold_y_d = -q_ext;
      fold_z_d = HALF_TURN;
    end else begin
      fold_x_d = i_ext;
      fold_y_d = q_ext;
      fold_z_d = '0;
    end
  end

  // Fold stage and control chains.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      zero_pipe_q <= '0;
      fold_x_q    <= '0;
      fold_y_q    <= '0;
      fold_z_q    <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      zero_pipe_q <= zero_pipe_d;
      fold_x_q    <= fold_x_d;
      fold_y_q    <= fold_y_d;
      fold_z_q    <= fold_z_d;
    end
  end

  assign xs[0] = fold_x_q;
  assign ys[0] = fold_y_q;
  assign zs[0] = fold_z_q;

  for (genvar k = 0; k < NIT; k++) begin : g_iter
    cordic_vec_stage #(.XW_P(XDW), .NBA(NBA), .K(k)) u_stage (
      .c     (c),
      .rst_n (rst_n),
      .x_i   (xs[k]),
      .y_i   (ys[k]),
      .z_i   (zs[k]),
      .x_o   (xs[k+1]),
      .y_o   (ys[k+1]),
      .z_o   (zs[k+1])
    );
  end

  // A zero vector has no defined angle; report phase 0 rather than the
  // sum of all table entries the iterations would otherwise accumulate.
  always_comb begin
    phase_d = zero_pipe_q[NIT] ? '0 : zs[NIT];
    mag_d   = xs[NIT][NBD+NG:NG];
  end

  // Output stage.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      mag_q   <= '0;
    end else begin
      phase_q <= phase_d;
      mag_q   <= mag_d;
    end
  end

  assign o_valid = vld_pipe_q[PIPE_LAT-1];
  assign o_phase = phase_q;
  assign o_mag   = mag_q;

  // Final residual y, the x sign bit and guard bits are intentionally dropped.
  logic unused_tail;
  assign unused_tail = ^{ys[NIT], xs[NIT][XDW-1], xs[NIT][NG-1:0]};

endmodule

// File: tb/tb_atan2_18.sv
// Directed vector bench for atan2_18: table vectors, reset corner cases,
// and a continuous phase-ramp stream checked against real-valued atan2.
module tb_atan2_18;

  localparam int LAT  = 22;
  localparam int TURN = 4194304;
  localparam real TWO_PI = 6.283185307179586;

  logic               c, rst_n, i_valid;
  logic signed [17:0] i_s, q_s;
  logic               o_valid;
  logic        [21:0] o_phase;
  logic        [18:0] o_mag;

  atan2_18 dut (
    .c       (c),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i       (i_s),
    .q       (q_s),
    .o_valid (o_valid),
    .o_phase (o_phase),
    .o_mag   (o_mag)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    int i;
    int q;
    int ph;
    int ph_tol;
    int mag;
    int mag_tol;
  } vec_t;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Signed phase difference, modulo one turn.
  function automatic int pdiff(input int a, input int b);
    int d;
    d = (a - b) & (TURN - 1);
    if (d >= TURN / 2) d = d - TURN;
    return d;
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Single-pulse vector: checks latency, phase, magnitude, pulse width.
  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    bit  seen;
    @(negedge c);
    i_s = 18'(v.i); q_s = 18'(v.q); i_valid = 1'b1;
    @(negedge c);
    i_valid = 1'b0;
    n = 1; seen = 1'b0;
    while (!seen && n <= 2 * LAT) begin
      if (o_valid) seen = 1'b1;
      else begin
        @(negedge c);
        n++;
      end
    end
    chk($sformatf("vec%0d latency", idx), seen && n == LAT, n, LAT);
    chk($sformatf("vec%0d phase", idx), seen && iabs(pdiff(int'(o_phase), v.ph)) <= v.ph_tol,
        o_phase, v.ph);
    chk($sformatf("vec%0d mag", idx), seen && iabs(int'(o_mag) - v.mag) <= v.mag_tol,
        o_mag, v.mag);
    @(negedge c);
    chk($sformatf("vec%0d pulse_end", idx), o_valid == 1'b0, o_valid, 0);
  endtask

  vec_t vecs [11];

  int   ph_q[$];
  real  mg_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    real kg, pk, ri, rq, pa, emg;
    int  ramp, ii, qq, eph, n_vld_bad, n_ph_bad, n_mg_bad, max_ph, max_mg_x10;
    int  n;
    bit  seen;

    // ideal vectors; expected values from atan2 / K*|v| worked out by hand
    vecs[0]  = '{131071, 0, 0, 8, 215843, 2};
    vecs[1]  = '{0, 131071, 1048576, 8, 215843, 2};
    vecs[2]  = '{-131072, 0, 2097152, 8, 215844, 2};
    vecs[3]  = '{0, -131072, 3145728, 8, 215844, 2};
    vecs[4]  = '{100000, -1, 4194297, 8, 164676, 2};
    vecs[5]  = '{0, 0, 0, 0, 0, 0};
    vecs[6]  = '{65536, 65536, 524288, 8, 152625, 2};
    vecs[7]  = '{-65536, 65536, 1572864, 8, 152625, 2};
    vecs[8]  = '{-65536, -65536, 2621440, 8, 152625, 2};
    vecs[9]  = '{65536, -65536, 3670016, 8, 152625, 2};
    vecs[10] = '{100000, 50000, 309505, 8, 184113, 2};

    kg = 1.0; pk = 1.0;
    for (int k = 0; k < 20; k++) begin
      kg = kg * $sqrt(1.0 + pk);
      pk = pk * 0.25;
    end

    // reset state: outputs held at zero while inputs toggle
    rst_n = 1'b0; i_valid = 1'b1; i_s = 18'sd1234; q_s = -18'sd777;
    repeat (3) @(negedge c);
    chk("reset o_valid", o_valid == 1'b0, o_valid, 0);
    chk("reset o_phase", o_phase == '0, o_phase, 0);
    chk("reset o_mag", o_mag == '0, o_mag, 0);
    i_valid = 1'b0;
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge c);
    chk("idle o_valid", o_valid == 1'b0, o_valid, 0);

    for (int v = 0; v < 11; v++) run_vec(vecs[v], v);

    // mid-stream reset: old samples must never surface after release
    @(negedge c);
    i_s = 18'sd0; q_s = 18'sd131071; i_valid = 1'b1;
    repeat (LAT + 4) @(negedge c);
    chk("stream o_valid", o_valid == 1'b1, o_valid, 1);
    rst_n = 1'b0;
    i_s = 18'sd131071; q_s = 18'sd0;
    #1;
    chk("async clr o_valid", o_valid == 1'b0, o_valid, 0);
    chk("async clr o_phase", o_phase == '0, o_phase, 0);
    chk("async clr o_mag", o_mag == '0, o_mag, 0);
    @(negedge c);
    rst_n = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 2 * LAT) begin
      @(negedge c);
      n++;
      if (o_valid) seen = 1'b1;
    end
    chk("post-reset latency", seen && n == LAT, n, LAT);
    chk("post-reset phase", iabs(pdiff(int'(o_phase), 0)) <= 8, o_phase, 0);
    chk("post-reset mag", iabs(int'(o_mag) - 215843) <= 2, o_mag, 215843);
    @(negedge c);
    chk("post-reset continues", o_valid == 1'b1, o_valid, 1);

    // continuous ramp-driven stream, reference is atan2 of the integer inputs
    n_vld_bad = 0; n_ph_bad = 0; n_mg_bad = 0; max_ph = 0; max_mg_x10 = 0;
    for (int s = 0; s < 10000 + LAT; s++) begin
      @(negedge c);
      if (s >= LAT) begin
        eph = ph_q.pop_front();
        emg = mg_q.pop_front();
        if (!o_valid) n_vld_bad++;
        if (iabs(pdiff(int'(o_phase), eph)) > max_ph) max_ph = iabs(pdiff(int'(o_phase), eph));
        if (iabs(pdiff(int'(o_phase), eph)) > 8) n_ph_bad++;
        if ($rtoi(10.0 * $sqrt((real'(o_mag) - emg) * (real'(o_mag) - emg))) > max_mg_x10)
          max_mg_x10 = $rtoi(10.0 * $sqrt((real'(o_mag) - emg) * (real'(o_mag) - emg)));
        if (real'(o_mag) - emg > 2.0 || emg - real'(o_mag) > 2.0) n_mg_bad++;
      end
      if (s < 10000) begin
        ramp = (s * 4099) % TURN;
        pa = TWO_PI * real'(ramp) / real'(TURN);
        ii = $rtoi($floor(125000.0 * $cos(pa) + 0.5));
        qq = $rtoi($floor(125000.0 * $sin(pa) + 0.5));
        ri = real'(ii); rq = real'(qq);
        pa = $atan2(rq, ri);
        if (pa < 0.0) pa = pa + TWO_PI;
        eph = $rtoi($floor(pa * real'(TURN) / TWO_PI + 0.5)) % TURN;
        ph_q.push_back(eph);
        mg_q.push_back(kg * $sqrt(ri * ri + rq * rq));
        i_s = 18'(ii); q_s = 18'(qq); i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
    end
    chk("ramp o_valid gaps", n_vld_bad == 0, n_vld_bad, 0);
    chk("ramp phase outliers", n_ph_bad == 0, max_ph, 8);
    chk("ramp mag outliers (x10)", n_mg_bad == 0, max_mg_x10, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
